// File: rtl/regfile_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard_pkg
// Shared definitions for the register-file scoreboard slice:
//   - default register width and register count
//   - address-width derivation from the register count
//   - index of the hard-wired zero register
// -----------------------------------------------------------------------------
package regfile_scoreboard_pkg;

    localparam int XLEN_DEFAULT = 64;
    localparam int NREG_DEFAULT = 32;
    localparam int X0_IDX       = 0;

    // Address width needed to select one of n registers (n is a power of two).
    function automatic int calc_aw(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard_if
// Writeback bus shared by the register file and its read ports.
//   wb_en   : writeback strobe
//   wb_rd   : writeback destination register
//   wb_data : writeback value
// master drives the bus, slave observes it (read ports use it for bypass and
// for masking the busy flag of a register being written back this cycle).
// -----------------------------------------------------------------------------
interface regfile_scoreboard_if
    import regfile_scoreboard_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int AW   = calc_aw(NREG_DEFAULT)
);

    logic            wb_en;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;

    modport master (output wb_en, output wb_rd, output wb_data);
    modport slave  (input  wb_en, input  wb_rd, input  wb_data);

endinterface

// File: rtl/regfile_scoreboard_rf_read_port.sv
// -----------------------------------------------------------------------------
// rf_read_port
// One combinational read port of the register file.
//   i_addr     : register selected by this port
//   i_arr_data : array contents of the selected register
//   i_arr_busy : scoreboard busy bit of the selected register
//   wb         : writeback bus (slave view)
//   o_data     : read data, with write-through bypass from the writeback bus
//   o_busy     : pending-write flag, cleared early when the writeback lands now
// -----------------------------------------------------------------------------
module rf_read_port
    import regfile_scoreboard_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int AW   = calc_aw(NREG_DEFAULT)
)(
    input  logic [AW-1:0]   i_addr,
    input  logic [XLEN-1:0] i_arr_data,
    input  logic            i_arr_busy,
    regfile_scoreboard_if.slave wb,
    output logic [XLEN-1:0] o_data,
    output logic            o_busy
);

    localparam logic [AW-1:0] X0 = AW'(X0_IDX);

    logic w_wb_hit;

    // Bypass and busy masking for the register addressed by this port.
    always_comb begin
        w_wb_hit = wb.wb_en && (wb.wb_rd == i_addr);
        // x0 is never bypassed so it always reads as zero from the array.
        if (w_wb_hit && (i_addr != X0)) begin
            o_data = wb.wb_data;
        end else begin
            o_data = i_arr_data;
        end
        o_busy = i_arr_busy && !w_wb_hit;
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// Register file with per-register busy scoreboard for an in-order issue stage.
//   clk, reset    : clock and synchronous active-high reset
//   rs_addr/data  : NRD combinational read ports with writeback bypass
//   rs_busy       : per-port "source has a pending write" flag
//   issue_*       : issue request; issue_ready reports no hazard
//   wb_*          : writeback into the array, clears the busy bit
//   pending_cnt   : registered count of busy registers
//   debug_*       : byte-wide debug peek into the array (no bypass)
// -----------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int  XLEN = XLEN_DEFAULT,
    parameter int  NREG = NREG_DEFAULT,
    parameter int  NRD  = 2,
    localparam int AW   = calc_aw(NREG)
)(
    input  logic              clk,
    input  logic              reset,
    input  logic [NRD*AW-1:0] rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]    rs_busy,
    input  logic              issue_valid,
    input  logic              issue_rd_en,
    input  logic [AW-1:0]     issue_rd,
    output logic              issue_ready,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic [AW:0]       pending_cnt,
    input  logic [AW-1:0]     debug_reg,
    input  logic [2:0]        debug_byte,
    output logic [7:0]        debug_data
);

    localparam logic [AW-1:0] X0      = AW'(X0_IDX);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(NREG-1);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_busy;
    logic [AW:0]     r_pending_cnt;

    logic            w_wb_fire;
    logic            w_dst_hazard;
    logic            w_issue_ready;
    logic            w_set;
    logic            w_inc;
    logic            w_dec;
    logic [XLEN-1:0] w_dbg_word;
    logic [7:0]      w_dbg_byte;

    regfile_scoreboard_if #(.XLEN(XLEN), .AW(AW)) u_wb_if ();

    assign u_wb_if.wb_en   = wb_en;
    assign u_wb_if.wb_rd   = wb_rd;
    assign u_wb_if.wb_data = wb_data;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] w_addr;
        assign w_addr = rs_addr[k*AW +: AW];

        rf_read_port #(.XLEN(XLEN), .AW(AW)) u_port (
            .i_addr     (w_addr),
            .i_arr_data (r_regs[w_addr]),
            .i_arr_busy (r_busy[w_addr]),
            .wb         (u_wb_if),
            .o_data     (rs_data[k*XLEN +: XLEN]),
            .o_busy     (rs_busy[k])
        );
    end

    // Hazard detection and scoreboard set/clear decisions.
    always_comb begin
        w_wb_fire    = wb_en && (wb_rd != X0);
        // A busy destination is fine when its writeback lands this very cycle.
        w_dst_hazard = issue_rd_en && (issue_rd != X0) && r_busy[issue_rd]
                       && !(wb_en && (wb_rd == issue_rd));
        // issue_valid is deliberately absent here to keep the handshake loop-free.
        w_issue_ready = (rs_busy == {NRD{1'b0}}) && !w_dst_hazard;
        w_set = issue_valid && w_issue_ready && issue_rd_en && (issue_rd != X0);
        // Count moves only on real 0->1 / 1->0 transitions of a busy bit; a
        // same-register set+clear leaves the bit set, so it is not a decrement.
        w_inc = w_set && !r_busy[issue_rd];
        w_dec = w_wb_fire && r_busy[wb_rd] && !(w_set && (issue_rd == wb_rd));
    end

    // Debug byte peek straight from the array.
    always_comb begin
        if (debug_reg == X0) begin
            w_dbg_word = {XLEN{1'b0}};
        end else begin
            w_dbg_word = r_regs[debug_reg];
        end
        if (int'(debug_byte) < (XLEN / 8)) begin
            w_dbg_byte = 8'(w_dbg_word >> (int'(debug_byte) * 8));
        end else begin
            w_dbg_byte = 8'h00;
        end
    end

    // Array, busy bits and pending counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= {XLEN{1'b0}};
            end
            r_busy        <= {NREG{1'b0}};
            r_pending_cnt <= {(AW+1){1'b0}};
        end else begin
            if (w_wb_fire) begin
                r_regs[wb_rd] <= wb_data;
                r_busy[wb_rd] <= 1'b0;
            end
            // Placed after the clear so a same-register set wins.
            if (w_set) begin
                r_busy[issue_rd] <= 1'b1;
            end
            case ({w_inc, w_dec})
                2'b10: begin
                    if (r_pending_cnt != CNT_MAX) begin
                        r_pending_cnt <= r_pending_cnt + {{AW{1'b0}}, 1'b1};
                    end
                end
                2'b01: begin
                    if (r_pending_cnt != {(AW+1){1'b0}}) begin
                        r_pending_cnt <= r_pending_cnt - {{AW{1'b0}}, 1'b1};
                    end
                end
                default: begin
                    r_pending_cnt <= r_pending_cnt;
                end
            endcase
        end
    end

    assign issue_ready = w_issue_ready;
    assign pending_cnt = r_pending_cnt;
    assign debug_data  = w_dbg_byte;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_regfile_scoreboard
// Directed scenarios followed by random traffic, all checked against a
// behavioural register-file/scoreboard model held in plain arrays.
// -----------------------------------------------------------------------------
module tb_regfile_scoreboard;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic                 clk;
    logic                 reset;
    logic [NRD*AW-1:0]    rs_addr;
    logic [NRD*XLEN-1:0]  rs_data;
    logic [NRD-1:0]       rs_busy;
    logic                 issue_valid;
    logic                 issue_rd_en;
    logic [AW-1:0]        issue_rd;
    logic                 issue_ready;
    logic [AW:0]          pending_cnt;
    logic [AW-1:0]        debug_reg;
    logic [2:0]           debug_byte;
    logic [7:0]           debug_data;

    regfile_scoreboard_if #(.XLEN(XLEN), .AW(AW)) bus ();

    regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
        .clk         (clk),
        .reset       (reset),
        .rs_addr     (rs_addr),
        .rs_data     (rs_data),
        .rs_busy     (rs_busy),
        .issue_valid (issue_valid),
        .issue_rd_en (issue_rd_en),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .wb_en       (bus.wb_en),
        .wb_rd       (bus.wb_rd),
        .wb_data     (bus.wb_data),
        .pending_cnt (pending_cnt),
        .debug_reg   (debug_reg),
        .debug_byte  (debug_byte),
        .debug_data  (debug_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural register values and outstanding writers.
    logic [XLEN-1:0] m_regs [NREG];
    bit              m_busy [NREG];
    int n_assert;
    int n_fail;

    function automatic int src(input int k);
        return int'(rs_addr[k*AW +: AW]);
    endfunction

    function automatic logic [XLEN-1:0] exp_data(input int a);
        if (bus.wb_en && bus.wb_rd != 5'd0 && int'(bus.wb_rd) == a) return bus.wb_data;
        return m_regs[a];
    endfunction

    function automatic bit exp_busy(input int a);
        return m_busy[a] && !(bus.wb_en && int'(bus.wb_rd) == a);
    endfunction

    function automatic bit exp_ready();
        for (int k = 0; k < NRD; k++) begin
            if (exp_busy(src(k))) return 1'b0;
        end
        if (issue_rd_en && issue_rd != 5'd0 && exp_busy(int'(issue_rd))) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < NREG; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [63:0] w;
        for (int k = 0; k < NRD; k++) begin
            chk($sformatf("rs_data%0d", k), rs_data[k*XLEN +: XLEN], exp_data(src(k)));
            chk($sformatf("rs_busy%0d", k), 64'(rs_busy[k]), 64'(exp_busy(src(k))));
        end
        chk("issue_ready", 64'(issue_ready), 64'(exp_ready()));
        chk("pending_cnt", 64'(pending_cnt), 64'(m_count()));
        w = m_regs[debug_reg] >> (8 * int'(debug_byte));
        chk("debug_data", 64'(debug_data), w & 64'hFF);
    endtask

    // Check current outputs, clock once, advance the model, step off the edge.
    task automatic tick();
        bit do_set;
        check_outputs();
        do_set = issue_valid && exp_ready() && issue_rd_en && issue_rd != 5'd0;
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (bus.wb_en && bus.wb_rd != 5'd0) begin
                m_regs[bus.wb_rd] = bus.wb_data;
                m_busy[bus.wb_rd] = 1'b0;
            end
            if (do_set) m_busy[issue_rd] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        reset       = 1'b0;
        issue_valid = 1'b0;
        issue_rd_en = 1'b0;
        issue_rd    = 5'd0;
        bus.wb_en   = 1'b0;
        bus.wb_rd   = 5'd0;
        bus.wb_data = 64'd0;
        rs_addr     = 10'd0;
        debug_reg   = 5'd0;
        debug_byte  = 3'd0;
    endtask

    task automatic issue(input logic [AW-1:0] rd);
        issue_valid = 1'b1;
        issue_rd_en = 1'b1;
        issue_rd    = rd;
    endtask

    task automatic wb(input logic [AW-1:0] rd, input logic [63:0] d);
        bus.wb_en   = 1'b1;
        bus.wb_rd   = rd;
        bus.wb_data = d;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        for (int i = 0; i < NREG; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        idle();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        tick();

        // Reset state: every register reads zero, nothing pending.
        idle();
        #1;
        chk("rst_ready", 64'(issue_ready), 64'd1);
        chk("rst_pending", 64'(pending_cnt), 64'd0);
        for (int a = 0; a < NREG; a++) begin
            rs_addr   = {5'(NREG - 1 - a), 5'(a)};
            debug_reg = 5'(a);
            #1;
            tick();
        end

        // Writeback bypass in the same cycle, then persistence and debug peek.
        idle();
        wb(5'd5, 64'hDEAD_BEEF_0123_4567);
        rs_addr = {5'd0, 5'd5};
        #1;
        chk("bypass_now", rs_data[63:0], 64'hDEAD_BEEF_0123_4567);
        tick();
        idle();
        rs_addr    = {5'd0, 5'd5};
        debug_reg  = 5'd5;
        debug_byte = 3'd7;
        #1;
        chk("x5_after", rs_data[63:0], 64'hDEAD_BEEF_0123_4567);
        chk("debug_de", 64'(debug_data), 64'hDE);
        tick();

        // RAW hazard on x3, resolved by its writeback.
        idle();
        issue(5'd3);
        #1;
        tick();
        idle();
        issue(5'd8);
        rs_addr = {5'd3, 5'd0};
        #1;
        chk("raw_stall", 64'(issue_ready), 64'd0);
        chk("raw_pending", 64'(pending_cnt), 64'd1);
        tick();
        issue_rd_en = 1'b0;
        wb(5'd3, 64'h33);
        #1;
        chk("raw_release", 64'(issue_ready), 64'd1);
        tick();
        idle();
        #1;
        chk("raw_cleared", 64'(pending_cnt), 64'd0);
        tick();

        // Issue and writeback of x7 together while x7 is busy: set wins.
        idle();
        issue(5'd7);
        #1;
        tick();
        wb(5'd7, 64'h77);
        #1;
        chk("ww_ready", 64'(issue_ready), 64'd1);
        tick();
        idle();
        rs_addr = {5'd0, 5'd7};
        #1;
        chk("ww_busy", 64'(rs_busy[0]), 64'd1);
        chk("ww_pending", 64'(pending_cnt), 64'd1);
        tick();
        idle();
        wb(5'd7, 64'h78);
        #1;
        tick();

        // x0: issue and writeback are both inert.
        idle();
        issue(5'd0);
        wb(5'd0, 64'hFF);
        #1;
        chk("x0_bypass", rs_data[63:0], 64'd0);
        tick();
        idle();
        #1;
        chk("x0_read", rs_data[63:0], 64'd0);
        chk("x0_pending", 64'(pending_cnt), 64'd0);
        tick();

        // Busy x4 and x9, then reset discards both pending writes.
        idle();
        issue(5'd4);
        #1;
        tick();
        issue(5'd9);
        #1;
        tick();
        idle();
        #1;
        chk("pre_rst_pending", 64'(pending_cnt), 64'd2);
        reset = 1'b1;
        issue(5'd12);
        wb(5'd6, 64'h66);
        #1;
        tick();
        idle();
        rs_addr = {5'd9, 5'd4};
        issue(5'd4);
        issue_valid = 1'b0;
        #1;
        chk("mid_rst_pending", 64'(pending_cnt), 64'd0);
        chk("mid_rst_ready", 64'(issue_ready), 64'd1);
        tick();
        idle();
        wb(5'd4, 64'h1234);
        #1;
        tick();
        idle();
        rs_addr = {5'd9, 5'd4};
        #1;
        chk("post_rst_busy", 64'(rs_busy), 64'd0);
        chk("post_rst_data", rs_data[63:0], 64'h1234);
        tick();

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            reset       = ($urandom_range(0, 59) == 0);
            issue_valid = $urandom_range(0, 1) == 1;
            issue_rd_en = $urandom_range(0, 3) != 0;
            issue_rd    = 5'($urandom_range(0, NREG - 1));
            bus.wb_en   = $urandom_range(0, 1) == 1;
            bus.wb_rd   = 5'($urandom_range(0, NREG - 1));
            bus.wb_data = {32'($urandom), 32'($urandom)};
            rs_addr     = 10'($urandom);
            debug_reg   = 5'($urandom_range(0, NREG - 1));
            debug_byte  = 3'($urandom_range(0, 7));
            #1;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
